// File: rtl/histeq_frame_sequencer.sv
// Phase controller for one histogram-equalization frame: sequences histogram,
// CDF and output stages, derives the output divisor and arbitrates the M2 read port.
module histeq_frame_sequencer #(
   parameter int NUM_PIXELS     = 262144,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        go,
   input  logic        abort,
   output logic        hist_start,
   input  logic        hist_done,
   output logic        cdf_start,
   input  logic        cdf_done,
   input  logic [19:0] cdf_min_in,
   output logic        out_start,
   input  logic        out_done,
   output logic [19:0] CdfMin,
   output logic [19:0] divisor,
   output logic [1:0]  m2sp_sel,
   output logic        output_base_offset,
   output logic        busy,
   output logic        frame_done,
   output logic        error,
   output logic [7:0]  frame_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_HIST, S_CDF, S_PARAM, S_OUT, S_FINISH, S_ERR
   } state_t;

   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [19:0] NPIX     = 20'(NUM_PIXELS);
   localparam logic [1:0]  SEL_NONE = 2'd3;

   state_t      state;
   logic [23:0] tmo_count;
   logic        timed_out;

   assign timed_out = (tmo_count == TMO_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state              <= S_IDLE;
         tmo_count          <= '0;
         hist_start         <= 1'b0;
         cdf_start          <= 1'b0;
         out_start          <= 1'b0;
         frame_done         <= 1'b0;
         error              <= 1'b0;
         busy               <= 1'b0;
         m2sp_sel           <= SEL_NONE;
         CdfMin             <= '0;
         divisor            <= 20'd1;
         output_base_offset <= 1'b0;
         frame_count        <= '0;
      end else begin
         hist_start <= 1'b0;
         cdf_start  <= 1'b0;
         out_start  <= 1'b0;
         frame_done <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            tmo_count <= '0;
            busy      <= 1'b0;
            error     <= 1'b0;
            m2sp_sel  <= SEL_NONE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (go) begin
                     state      <= S_HIST;
                     tmo_count  <= '0;
                     hist_start <= 1'b1;
                     busy       <= 1'b1;
                     m2sp_sel   <= 2'd0;
                  end
               end
               S_HIST: begin
                  if (hist_done) begin
                     state     <= S_CDF;
                     tmo_count <= '0;
                     cdf_start <= 1'b1;
                     m2sp_sel  <= 2'd1;
                  end else if (timed_out) begin
                     state     <= S_ERR;
                     tmo_count <= '0;
                     busy      <= 1'b0;
                     error     <= 1'b1;
                     m2sp_sel  <= SEL_NONE;
                  end else begin
                     tmo_count <= tmo_count + 24'd1;
                  end
               end
               S_CDF: begin
                  if (cdf_done) begin
                     state     <= S_PARAM;
                     tmo_count <= '0;
                     CdfMin    <= cdf_min_in;
                     m2sp_sel  <= SEL_NONE;
                  end else if (timed_out) begin
                     state     <= S_ERR;
                     tmo_count <= '0;
                     busy      <= 1'b0;
                     error     <= 1'b1;
                     m2sp_sel  <= SEL_NONE;
                  end else begin
                     tmo_count <= tmo_count + 24'd1;
                  end
               end
               S_PARAM: begin
                  // A CdfMin at or above the pixel count would give a zero or
                  // wrapped divisor; clamp to 1 so the output stage never divides by 0.
                  state     <= S_OUT;
                  tmo_count <= '0;
                  out_start <= 1'b1;
                  m2sp_sel  <= 2'd2;
                  divisor   <= (CdfMin < NPIX) ? (NPIX - CdfMin) : 20'd1;
               end
               S_OUT: begin
                  if (out_done) begin
                     state              <= S_FINISH;
                     tmo_count          <= '0;
                     frame_done         <= 1'b1;
                     output_base_offset <= ~output_base_offset;
                     frame_count        <= frame_count + 8'd1;
                     m2sp_sel           <= SEL_NONE;
                  end else if (timed_out) begin
                     state     <= S_ERR;
                     tmo_count <= '0;
                     busy      <= 1'b0;
                     error     <= 1'b1;
                     m2sp_sel  <= SEL_NONE;
                  end else begin
                     tmo_count <= tmo_count + 24'd1;
                  end
               end
               S_FINISH: begin
                  state     <= S_IDLE;
                  tmo_count <= '0;
                  busy      <= 1'b0;
               end
               S_ERR: begin
                  state <= S_ERR;
               end
               default: begin
                  state     <= S_IDLE;
                  tmo_count <= '0;
                  busy      <= 1'b0;
                  error     <= 1'b0;
                  m2sp_sel  <= SEL_NONE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_histeq_frame_sequencer.sv
// Self-checking bench for histeq_frame_sequencer: randomized frames, strays,
// timeouts, abort and wrap checked against a frame-level reference model.
module tb_histeq_frame_sequencer;
   localparam int NPIX = 262144;
   localparam int TMO  = 16;

   logic        clock = 1'b0;
   logic        reset_n, go, abort, hist_done, cdf_done, out_done;
   logic [19:0] cdf_min_in;
   logic        hist_start, cdf_start, out_start, output_base_offset, busy, frame_done, error;
   logic [19:0] CdfMin, divisor;
   logic [1:0]  m2sp_sel;
   logic [7:0]  frame_count;

   int          checks = 0;
   int          errors = 0;
   int          exp_count = 0;
   logic        exp_offset = 1'b0;
   logic [19:0] exp_cdfmin = '0;
   logic [19:0] exp_div = 20'd1;

   always #5 clock = ~clock;

   histeq_frame_sequencer #(.NUM_PIXELS(NPIX), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .abort(abort),
      .hist_start(hist_start), .hist_done(hist_done),
      .cdf_start(cdf_start), .cdf_done(cdf_done), .cdf_min_in(cdf_min_in),
      .out_start(out_start), .out_done(out_done),
      .CdfMin(CdfMin), .divisor(divisor), .m2sp_sel(m2sp_sel),
      .output_base_offset(output_base_offset), .busy(busy),
      .frame_done(frame_done), .error(error), .frame_count(frame_count)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [19:0] ref_div(input logic [19:0] m);
      if (int'(m) < NPIX) return 20'(NPIX - int'(m));
      return 20'd1;
   endfunction

   function automatic logic coin(input bit en);
      return en && ($urandom_range(0, 1) == 1);
   endfunction

   // Drive a fresh frame from IDLE to the first cycle of phase 0/1/2 (HIST/CDF/OUT).
   task automatic enter_phase(input int phase, input logic [19:0] cmin);
      go = 1'b1; step(); go = 1'b0;
      if (phase >= 1) begin hist_done = 1'b1; step(); hist_done = 1'b0; end
      if (phase >= 2) begin
         cdf_done = 1'b1; cdf_min_in = cmin; step(); cdf_done = 1'b0;
         exp_cdfmin = cmin; exp_div = ref_div(cmin);
         step();
      end
   endtask

   task automatic run_frame(input string tag, input int hl, input int cl, input int ol,
                            input logic [19:0] cmin, input bit stray);
      go = 1'b1; step(); go = 1'b0;
      checks++;
      if ({hist_start, busy, error, m2sp_sel} !== 5'b11000) begin
         errors++; $display("FAIL %s hist_entry: got %b want 11000", tag, {hist_start, busy, error, m2sp_sel});
      end
      for (int i = 0; i < hl; i++) begin
         out_done = coin(stray); cdf_done = coin(stray); step();
         checks++;
         if ({hist_start, cdf_start, busy, m2sp_sel} !== 5'b00100) begin
            errors++; $display("FAIL %s hist_wait[%0d]: got %b want 00100", tag, i, {hist_start, cdf_start, busy, m2sp_sel});
         end
      end
      out_done = 1'b0; cdf_done = 1'b0; hist_done = 1'b1; step(); hist_done = 1'b0;
      checks++;
      if ({hist_start, cdf_start, m2sp_sel} !== 4'b0101) begin
         errors++; $display("FAIL %s cdf_entry: got %b want 0101", tag, {hist_start, cdf_start, m2sp_sel});
      end
      for (int i = 0; i < cl; i++) begin
         hist_done = coin(stray); out_done = coin(stray); cdf_min_in = 20'($urandom); step();
         checks++;
         if ({cdf_start, busy, error, m2sp_sel} !== 5'b01001) begin
            errors++; $display("FAIL %s cdf_wait[%0d]: got %b want 01001", tag, i, {cdf_start, busy, error, m2sp_sel});
         end
      end
      hist_done = 1'b0; out_done = 1'b0; cdf_done = 1'b1; cdf_min_in = cmin; step(); cdf_done = 1'b0;
      exp_cdfmin = cmin;
      checks++;
      if ({cdf_start, out_start, busy, error, m2sp_sel} !== 6'b001011) begin
         errors++; $display("FAIL %s param_state: got %b want 001011", tag, {cdf_start, out_start, busy, error, m2sp_sel});
      end
      checks++;
      if (CdfMin !== exp_cdfmin) begin
         errors++; $display("FAIL %s cdfmin: got %0d want %0d", tag, CdfMin, exp_cdfmin);
      end
      step();
      exp_div = ref_div(cmin);
      checks++;
      if ({out_start, m2sp_sel} !== 3'b110) begin
         errors++; $display("FAIL %s out_entry: got %b want 110", tag, {out_start, m2sp_sel});
      end
      checks++;
      if (divisor !== exp_div) begin
         errors++; $display("FAIL %s divisor: got %0d want %0d", tag, divisor, exp_div);
      end
      for (int i = 0; i < ol; i++) begin
         hist_done = coin(stray); cdf_done = coin(stray); step();
         checks++;
         if ({out_start, frame_done, busy, m2sp_sel} !== 5'b00110) begin
            errors++; $display("FAIL %s out_wait[%0d]: got %b want 00110", tag, i, {out_start, frame_done, busy, m2sp_sel});
         end
      end
      hist_done = 1'b0; cdf_done = 1'b0; out_done = 1'b1; step(); out_done = 1'b0;
      exp_count  = (exp_count + 1) % 256;
      exp_offset = ~exp_offset;
      checks++;
      if ({frame_done, out_start, busy, m2sp_sel} !== 5'b10111) begin
         errors++; $display("FAIL %s finish_state: got %b want 10111", tag, {frame_done, out_start, busy, m2sp_sel});
      end
      checks++;
      if ({frame_count, output_base_offset} !== {8'(exp_count), exp_offset}) begin
         errors++; $display("FAIL %s count_offset: got %0d/%0b want %0d/%0b", tag, frame_count, output_base_offset, exp_count, exp_offset);
      end
      step();
      checks++;
      if ({frame_done, busy, error, m2sp_sel} !== 5'b00011) begin
         errors++; $display("FAIL %s back_idle: got %b want 00011", tag, {frame_done, busy, error, m2sp_sel});
      end
      checks++;
      if ({CdfMin, divisor} !== {exp_cdfmin, exp_div}) begin
         errors++; $display("FAIL %s params_stable: got %0d/%0d want %0d/%0d", tag, CdfMin, divisor, exp_cdfmin, exp_div);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; go = 0; abort = 0; hist_done = 0; cdf_done = 0; out_done = 0; cdf_min_in = '0;
      step(); step();
      reset_n = 1'b1;
      checks++;
      if ({hist_start, cdf_start, out_start, frame_done, error, busy, m2sp_sel} !== 8'b00000011) begin
         errors++; $display("FAIL reset_ctrl: got %b want 00000011", {hist_start, cdf_start, out_start, frame_done, error, busy, m2sp_sel});
      end
      checks++;
      if ({CdfMin, divisor, output_base_offset, frame_count} !== {20'd0, 20'd1, 1'b0, 8'd0}) begin
         errors++; $display("FAIL reset_data: got %0d/%0d/%0b/%0d want 0/1/0/0", CdfMin, divisor, output_base_offset, frame_count);
      end
      exp_count = 0; exp_offset = 1'b0; exp_cdfmin = '0; exp_div = 20'd1;
   endtask

   task automatic test_nominal();
      run_frame("nominal", 10, 4, 6, 20'd100, 1'b0);
      checks++;
      if ({divisor, frame_count, output_base_offset} !== {20'd262044, 8'd1, 1'b1}) begin
         errors++; $display("FAIL nominal_result: got %0d/%0d/%0b want 262044/1/1", divisor, frame_count, output_base_offset);
      end
   endtask

   task automatic test_degenerate();
      run_frame("degen_eq", 2, 2, 2, 20'd262144, 1'b0);
      checks++;
      if (divisor !== 20'd1) begin
         errors++; $display("FAIL degen_eq_div: got %0d want 1", divisor);
      end
      run_frame("degen_m1", 2, 2, 2, 20'd262143, 1'b0);
      checks++;
      if (divisor !== 20'd1) begin
         errors++; $display("FAIL degen_m1_div: got %0d want 1", divisor);
      end
   endtask

   task automatic test_stray();
      for (int i = 0; i < 6; i++) begin
         hist_done = coin(1); cdf_done = coin(1); out_done = coin(1); step();
         checks++;
         if ({hist_start, cdf_start, out_start, busy, m2sp_sel} !== 6'b000011) begin
            errors++; $display("FAIL stray_idle[%0d]: got %b want 000011", i, {hist_start, cdf_start, out_start, busy, m2sp_sel});
         end
      end
      hist_done = 0; cdf_done = 0; out_done = 0;
      run_frame("stray", 5, 5, 5, 20'($urandom_range(0, 300000)), 1'b1);
      run_frame("early_hist", 0, 0, 0, 20'd7, 1'b1);
   endtask

   task automatic test_go_abort_idle();
      go = 1'b1; abort = 1'b1; step(); go = 1'b0; abort = 1'b0;
      checks++;
      if ({hist_start, busy, m2sp_sel} !== 4'b0011) begin
         errors++; $display("FAIL go_abort_idle: got %b want 0011", {hist_start, busy, m2sp_sel});
      end
   endtask

   task automatic test_timeout(input int phase);
      enter_phase(phase, 20'($urandom_range(0, 262143)));
      for (int i = 0; i < TMO - 1; i++) begin
         step();
         checks++;
         if ({error, busy, m2sp_sel} !== {2'b01, 2'(phase)}) begin
            errors++; $display("FAIL timeout%0d_wait[%0d]: got %b want %b", phase, i, {error, busy, m2sp_sel}, {2'b01, 2'(phase)});
         end
      end
      step();
      checks++;
      if ({error, busy, m2sp_sel} !== 4'b1011) begin
         errors++; $display("FAIL timeout%0d_err: got %b want 1011", phase, {error, busy, m2sp_sel});
      end
      go = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({error, busy, hist_start, m2sp_sel} !== 5'b10011) begin
            errors++; $display("FAIL timeout%0d_go_ignored: got %b want 10011", phase, {error, busy, hist_start, m2sp_sel});
         end
      end
      go = 1'b0; abort = 1'b1; step(); abort = 1'b0;
      checks++;
      if ({error, busy, m2sp_sel} !== 4'b0011) begin
         errors++; $display("FAIL timeout%0d_abort: got %b want 0011", phase, {error, busy, m2sp_sel});
      end
      checks++;
      if ({frame_count, output_base_offset, CdfMin} !== {8'(exp_count), exp_offset, exp_cdfmin}) begin
         errors++; $display("FAIL timeout%0d_retained: got %0d/%0b/%0d want %0d/%0b/%0d", phase, frame_count, output_base_offset, CdfMin, exp_count, exp_offset, exp_cdfmin);
      end
   endtask

   task automatic test_done_vs_timeout();
      run_frame("late_done", TMO - 1, TMO - 1, TMO - 1, 20'($urandom_range(1, 262143)), 1'b0);
   endtask

   task automatic test_abort_out();
      enter_phase(2, 20'($urandom_range(0, 262143)));
      step(); step();
      abort = 1'b1; out_done = 1'b1; step(); abort = 1'b0; out_done = 1'b0;
      checks++;
      if ({busy, error, frame_done, out_start, m2sp_sel} !== 6'b000011) begin
         errors++; $display("FAIL abort_out_ctrl: got %b want 000011", {busy, error, frame_done, out_start, m2sp_sel});
      end
      checks++;
      if ({frame_count, output_base_offset, CdfMin, divisor} !== {8'(exp_count), exp_offset, exp_cdfmin, exp_div}) begin
         errors++; $display("FAIL abort_out_data: got %0d/%0b/%0d/%0d want %0d/%0b/%0d/%0d", frame_count, output_base_offset, CdfMin, divisor, exp_count, exp_offset, exp_cdfmin, exp_div);
      end
      run_frame("after_abort", 3, 3, 3, 20'd5000, 1'b0);
   endtask

   task automatic test_random_frames();
      logic [19:0] m;
      for (int f = 0; f < 20; f++) begin
         case ($urandom_range(0, 3))
            0:       m = 20'($urandom);
            1:       m = 20'(NPIX - 1 + $urandom_range(0, 2));
            default: m = 20'($urandom_range(0, NPIX - 1));
         endcase
         run_frame("rand", $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                   $urandom_range(0, TMO - 1), m, 1'b1);
      end
   endtask

   task automatic test_reset_mid_cdf();
      enter_phase(1, 20'd0);
      step(); step();
      reset_n = 1'b0; step(); reset_n = 1'b1;
      checks++;
      if ({hist_start, cdf_start, out_start, frame_done, error, busy, m2sp_sel} !== 8'b00000011) begin
         errors++; $display("FAIL reset_mid_ctrl: got %b want 00000011", {hist_start, cdf_start, out_start, frame_done, error, busy, m2sp_sel});
      end
      checks++;
      if ({CdfMin, divisor, output_base_offset, frame_count} !== {20'd0, 20'd1, 1'b0, 8'd0}) begin
         errors++; $display("FAIL reset_mid_data: got %0d/%0d/%0b/%0d want 0/1/0/0", CdfMin, divisor, output_base_offset, frame_count);
      end
      exp_count = 0; exp_offset = 1'b0; exp_cdfmin = '0; exp_div = 20'd1;
   endtask

   task automatic test_wrap();
      for (int f = 0; f < 256; f++)
         run_frame("wrap", $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   20'($urandom_range(0, NPIX + 10)), 1'b0);
      checks++;
      if ({frame_count, output_base_offset} !== 9'd0) begin
         errors++; $display("FAIL wrap_result: got %0d/%0b want 0/0", frame_count, output_base_offset);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_degenerate();
      test_stray();
      test_go_abort_idle();
      test_timeout(0);
      test_timeout(1);
      test_timeout(2);
      test_done_vs_timeout();
      test_abort_out();
      test_random_frames();
      test_reset_mid_cdf();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
